mmio_gpio: RTL and testbench

MMIO_GPIO -- requirements
Module: mmio_gpio

---
 rtl/mmio_gpio.sv | 162 ++++++++++++++++
 tb/tb_mmio_gpio.sv | 430 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mmio_gpio.sv
// mmio_gpio: memory-mapped switch/LED block with per-bit debounce,
// edge-selectable sticky interrupt status and a registered level irq.
module mmio_gpio #(
  parameter int unsigned NUM_IN          = 16,
  parameter int unsigned NUM_OUT         = 16,
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter logic [31:0] BASE_ADDR       = 32'h0000_1000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               readEnable,
  input  logic [3:0]         writeByteSelect,
  input  logic [31:0]        address,
  input  logic [31:0]        dataIn,
  output logic [31:0]        dataOut,
  output logic               readValid,
  input  logic [NUM_IN-1:0]  sw,
  output logic [NUM_OUT-1:0] leds,
  output logic               irq
);

  localparam logic [15:0] DEB = 16'(DEBOUNCE_CYCLES);

  localparam logic [5:0] OFF_IN  = 6'd0;
  localparam logic [5:0] OFF_OUT = 6'd1;
  localparam logic [5:0] OFF_EN  = 6'd2;
  localparam logic [5:0] OFF_ST  = 6'd3;
  localparam logic [5:0] OFF_SEL = 6'd4;

  // Release after one edge so an access on the 2nd edge lands
  logic rst_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) rst_q <= 1'b0;
    else      rst_q <= 1'b1;
  end

  logic               sel;
  logic               rd;
  logic               wr;
  logic [5:0]         word;
  logic [31:0]        wmask;
  logic               hit_in;
  logic               hit_out;
  logic               hit_en;
  logic               hit_st;
  logic               hit_sel;

  assign sel     = address[31:8] == BASE_ADDR[31:8];
  assign word    = address[7:2];
  assign rd      = sel & readEnable;
  assign wr      = sel & (|writeByteSelect);
  assign wmask   = {{8{writeByteSelect[3]}},
                    {8{writeByteSelect[2]}},
                    {8{writeByteSelect[1]}},
                    {8{writeByteSelect[0]}}};
  assign hit_in  = word == OFF_IN;
  assign hit_out = word == OFF_OUT;
  assign hit_en  = word == OFF_EN;
  assign hit_st  = word == OFF_ST;
  assign hit_sel = word == OFF_SEL;

  logic [NUM_IN-1:0]  in_wm;
  logic [NUM_IN-1:0]  in_wd;
  logic [NUM_OUT-1:0] out_wm;
  logic [NUM_OUT-1:0] out_wd;

  assign in_wm  = wmask[NUM_IN-1:0];
  assign in_wd  = dataIn[NUM_IN-1:0];
  assign out_wm = wmask[NUM_OUT-1:0];
  assign out_wd = dataIn[NUM_OUT-1:0];

  logic unused;
  assign unused = &{1'b0, address[1:0], dataIn, wmask};

  logic [NUM_OUT-1:0] out_r;
  logic [NUM_IN-1:0]  en_r;
  logic [NUM_IN-1:0]  st_r;
  logic [NUM_IN-1:0]  esel_r;
  logic [NUM_IN-1:0]  s1;
  logic [NUM_IN-1:0]  s2;
  logic [NUM_IN-1:0]  filt;
  logic [15:0]        cnt [NUM_IN];

  logic [NUM_IN-1:0]  filt_nxt;
  logic [15:0]        cnt_nxt [NUM_IN];
  logic [NUM_IN-1:0]  set;
  logic [NUM_IN-1:0]  clr;

  always_comb begin
    filt_nxt = filt;
    for (int i = 0; i < NUM_IN; i++) begin
      cnt_nxt[i] = '0;
      if (s2[i] != filt[i]) begin
        if (cnt[i] + 16'd1 == DEB) filt_nxt[i] = s2[i];
        else                       cnt_nxt[i]  = cnt[i] + 16'd1;
      end
    end
  end

  assign set = (~filt & filt_nxt & ~esel_r)
             | (filt & ~filt_nxt & esel_r);
  assign clr = (wr && hit_st) ? (in_wd & in_wm) : '0;

  always_ff @(posedge clk or negedge rst_q) begin
    if (!rst_q) begin
      s1   <= '0;
      s2   <= '0;
      filt <= '0;
      for (int i = 0; i < NUM_IN; i++) cnt[i] <= '0;
    end else begin
      s1   <= sw;
      s2   <= s1;
      filt <= filt_nxt;
      for (int i = 0; i < NUM_IN; i++) cnt[i] <= cnt_nxt[i];
    end
  end

  // Edge set beats a same-edge W1C clear
  always_ff @(posedge clk or negedge rst_q) begin
    if (!rst_q) begin
      out_r  <= '0;
      en_r   <= '0;
      st_r   <= '0;
      esel_r <= '0;
    end else begin
      if (wr && hit_out) out_r <= (out_r & ~out_wm) | (out_wd & out_wm);
      if (wr && hit_en)  en_r <= (en_r & ~in_wm) | (in_wd & in_wm);
      if (wr && hit_sel) esel_r <= (esel_r & ~in_wm) | (in_wd & in_wm);
      st_r <= (st_r & ~clr) | set;
    end
  end

  logic [31:0] rdata;

  always_comb begin
    rdata = '0;
    unique case (1'b1)
      hit_in:  rdata = 32'(filt);
      hit_out: rdata = 32'(out_r);
      hit_en:  rdata = 32'(en_r);
      hit_st:  rdata = 32'(st_r);
      hit_sel: rdata = 32'(esel_r);
      default: rdata = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_q) begin
    if (!rst_q) begin
      dataOut   <= '0;
      readValid <= 1'b0;
      irq       <= 1'b0;
    end else begin
      readValid <= rd;
      if (rd) dataOut <= rdata;
      irq <= |(st_r & en_r);
    end
  end

  assign leds = out_r;

endmodule

// File: tb/tb_mmio_gpio.sv
// tb_mmio_gpio: directed and randomized checks of mmio_gpio against
// a bus-level reference model with window-based debounce.
module tb_mmio_gpio;

  localparam int          DEB  = 4;
  localparam logic [31:0] BASE = 32'h0000_1000;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        readEnable = 1'b0;
  logic [3:0]  wbs = 4'h0;
  logic [31:0] address = 32'h0;
  logic [31:0] dataIn = 32'h0;
  logic [31:0] dataOut;
  logic        readValid;
  logic [15:0] sw = 16'h0;
  logic [15:0] leds;
  logic        irq;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  mmio_gpio #(
    .NUM_IN(16),
    .NUM_OUT(16),
    .DEBOUNCE_CYCLES(DEB),
    .BASE_ADDR(BASE)
  ) dut (
    .clk(clk),
    .rst(rst),
    .readEnable(readEnable),
    .writeByteSelect(wbs),
    .address(address),
    .dataIn(dataIn),
    .dataOut(dataOut),
    .readValid(readValid),
    .sw(sw),
    .leds(leds),
    .irq(irq)
  );

  // Reference model state
  logic [15:0] m_out, m_en, m_st, m_sel, m_filt;
  logic [31:0] m_dout;
  logic        m_rv, m_irq;
  bit          m_live;
  logic [15:0] hist [$];

  function automatic logic [31:0] m_reg(input logic [5:0] w);
    case (w)
      6'd0:    return {16'h0, m_filt};
      6'd1:    return {16'h0, m_out};
      6'd2:    return {16'h0, m_en};
      6'd3:    return {16'h0, m_st};
      6'd4:    return {16'h0, m_sel};
      default: return 32'h0;
    endcase
  endfunction

  // hist[0] is sw before the previous edge; the logic at an edge
  // sees sw from two edges back through the synchronizer.
  task automatic model_edge();
    logic [15:0] nf, setb, clr, msk, hv;
    logic        all, s;
    logic [5:0]  w;
    s = address[31:8] == BASE[31:8];
    w = address[7:2];
    m_irq = |(m_st & m_en);
    m_rv = s && readEnable;
    if (m_rv) m_dout = m_reg(w);
    nf = m_filt;
    for (int b = 0; b < 16; b++) begin
      all = 1'b1;
      for (int j = 1; j <= DEB; j++) begin
        hv = hist[j];
        if (hv[b] == m_filt[b]) all = 1'b0;
      end
      if (all) nf[b] = ~m_filt[b];
    end
    setb = (~m_filt & nf & ~m_sel) | (m_filt & ~nf & m_sel);
    clr = 16'h0;
    msk = {{8{wbs[1]}}, {8{wbs[0]}}};
    if (s && wbs != 4'h0) begin
      case (w)
        6'd1: m_out = (m_out & ~msk) | (dataIn[15:0] & msk);
        6'd2: m_en = (m_en & ~msk) | (dataIn[15:0] & msk);
        6'd3: clr = dataIn[15:0] & msk;
        6'd4: m_sel = (m_sel & ~msk) | (dataIn[15:0] & msk);
        default: ;
      endcase
    end
    m_st = (m_st & ~clr) | setb;
    m_filt = nf;
    hist.push_front(sw);
    void'(hist.pop_back());
  endtask

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_out = 0; m_en = 0; m_st = 0; m_sel = 0; m_filt = 0;
      m_dout = 0; m_rv = 0; m_irq = 0; m_live = 0;
      hist.delete();
      for (int j = 0; j < DEB + 2; j++) hist.push_back(16'h0);
    end else if (!m_live) begin
      m_live = 1;
      hist.push_front(16'h0);
      void'(hist.pop_back());
    end else begin
      model_edge();
    end
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic bus_write(input logic [7:0] off, input logic [31:0] d,
                           input logic [3:0] be);
    address = BASE | 32'(off);
    dataIn  = d;
    wbs     = be;
    @(negedge clk);
    wbs = 4'h0;
  endtask

  task automatic bus_read(input logic [31:0] addr);
    address    = addr;
    readEnable = 1'b1;
    @(negedge clk);
    readEnable = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    idle(3);
    tests++;
    if (leds !== 16'h0) begin
      fails++; $display("FAIL reset_leds: got %h want %h", leds, 16'h0);
    end
    tests++;
    if (irq !== 1'b0) begin
      fails++; $display("FAIL reset_irq: got %b want 0", irq);
    end
    tests++;
    if (readValid !== 1'b0) begin
      fails++; $display("FAIL reset_rv: got %b want 0", readValid);
    end
    tests++;
    if (dataOut !== 32'h0) begin
      fails++; $display("FAIL reset_dout: got %h want 0", dataOut);
    end
    rst = 1'b1;
    idle(1);
    bus_write(8'h04, 32'h0000_005A, 4'b0001);
    tests++;
    if (leds !== 16'h005A) begin
      fails++; $display("FAIL first_access: got %h want %h", leds, 16'h005A);
    end
  endtask

  task automatic test_rw();
    logic [7:0]  offs [3];
    logic [7:0]  o;
    logic [15:0] prev;
    logic [31:0] d;
    offs[0] = 8'h04; offs[1] = 8'h08; offs[2] = 8'h10;
    bus_write(8'h04, 32'h0000_A5A5, 4'b0001);
    tests++;
    if (leds !== 16'h00A5) begin
      fails++; $display("FAIL out_lane0: got %h want %h", leds, 16'h00A5);
    end
    bus_read(BASE | 32'h4);
    tests++;
    if (readValid !== 1'b1 || dataOut !== 32'h0000_00A5) begin
      fails++;
      $display("FAIL out_read: got %b/%h want 1/%h", readValid, dataOut, 32'hA5);
    end
    idle(1);
    tests++;
    if (readValid !== 1'b0 || dataOut !== 32'h0000_00A5) begin
      fails++;
      $display("FAIL read_hold: got %b/%h want 0/%h", readValid, dataOut, 32'hA5);
    end
    for (int i = 0; i < 8; i++) begin
      o = offs[$urandom_range(0, 2)];
      bus_write(o, $urandom, 4'($urandom));
      bus_read(BASE | 32'(o));
      tests++;
      if (readValid !== 1'b1 || dataOut !== m_dout) begin
        fails++;
        $display("FAIL rw_%h: got %b/%h want 1/%h", o, readValid, dataOut, m_dout);
      end
    end
    prev = m_out;
    d = $urandom;
    address = BASE | 32'h4;
    dataIn = d;
    wbs = 4'hF;
    readEnable = 1'b1;
    @(negedge clk);
    wbs = 4'h0;
    readEnable = 1'b0;
    tests++;
    if (dataOut !== {16'h0, prev} || leds !== d[15:0]) begin
      fails++;
      $display("FAIL rd_wr_same: got %h/%h want %h/%h",
               dataOut, leds, {16'h0, prev}, d[15:0]);
    end
  endtask

  task automatic irq_setup(input logic [15:0] en, input logic [15:0] es);
    bus_write(8'h08, 32'h0, 4'hF);
    bus_write(8'h0C, 32'hFFFF, 4'hF);
    bus_write(8'h10, 32'(es), 4'hF);
    bus_write(8'h08, 32'(en), 4'hF);
    idle(2);
  endtask

  task automatic test_debounce();
    irq_setup(16'h0001, 16'h0000);
    sw[0] = 1'b1;
    idle(4);
    address = BASE;
    readEnable = 1'b1;
    idle(1);
    tests++;
    if (irq !== 1'b0) begin
      fails++; $display("FAIL deb_irq_e5: got %b want 0", irq);
    end
    idle(1);
    tests++;
    if (dataOut[0] !== 1'b0 || irq !== 1'b0) begin
      fails++; $display("FAIL deb_e6: got in0=%b irq=%b want 0/0", dataOut[0], irq);
    end
    idle(1);
    readEnable = 1'b0;
    tests++;
    if (dataOut[0] !== 1'b1 || irq !== 1'b1) begin
      fails++; $display("FAIL deb_e7: got in0=%b irq=%b want 1/1", dataOut[0], irq);
    end
    bus_read(BASE | 32'hC);
    tests++;
    if (dataOut[0] !== 1'b1) begin
      fails++; $display("FAIL deb_status: got %b want 1", dataOut[0]);
    end
  endtask

  task automatic test_glitch();
    sw[3] = 1'b1;
    idle(3);
    sw[3] = 1'b0;
    idle(10);
    bus_read(BASE);
    tests++;
    if (dataOut[3] !== 1'b0 || dataOut !== m_dout) begin
      fails++; $display("FAIL glitch_in: got %h want %h", dataOut, m_dout);
    end
    bus_read(BASE | 32'hC);
    tests++;
    if (dataOut[3] !== 1'b0) begin
      fails++; $display("FAIL glitch_status: got %b want 0", dataOut[3]);
    end
  endtask

  task automatic test_falling();
    irq_setup(16'h0000, 16'h0002);
    sw[1] = 1'b1;
    idle(12);
    bus_read(BASE | 32'hC);
    tests++;
    if (dataOut[1] !== 1'b0) begin
      fails++; $display("FAIL fall_on_rise: got %b want 0", dataOut[1]);
    end
    bus_read(BASE);
    tests++;
    if (dataOut[1] !== 1'b1) begin
      fails++; $display("FAIL fall_in_high: got %b want 1", dataOut[1]);
    end
    sw[1] = 1'b0;
    idle(12);
    bus_read(BASE | 32'hC);
    tests++;
    if (dataOut[1] !== 1'b1) begin
      fails++; $display("FAIL fall_on_fall: got %b want 1", dataOut[1]);
    end
  endtask

  task automatic test_w1c_race();
    irq_setup(16'h0004, 16'h0000);
    sw[2] = 1'b1;
    idle(5);
    address = BASE | 32'hC;
    dataIn = 32'h4;
    wbs = 4'b0001;
    @(negedge clk);
    wbs = 4'h0;
    idle(1);
    tests++;
    if (irq !== 1'b1) begin
      fails++; $display("FAIL race_irq: got %b want 1", irq);
    end
    bus_read(BASE | 32'hC);
    tests++;
    if (dataOut[2] !== 1'b1) begin
      fails++; $display("FAIL race_status: got %b want 1", dataOut[2]);
    end
    bus_write(8'h0C, 32'h4, 4'b0001);
    tests++;
    if (irq !== 1'b1) begin
      fails++; $display("FAIL w1c_irq_lag: got %b want 1", irq);
    end
    idle(1);
    tests++;
    if (irq !== 1'b0) begin
      fails++; $display("FAIL w1c_irq_drop: got %b want 0", irq);
    end
    sw[2] = 1'b0;
    idle(12);
  endtask

  task automatic test_unmapped();
    bus_read(BASE | 32'h1C);
    tests++;
    if (readValid !== 1'b1 || dataOut !== 32'h0) begin
      fails++; $display("FAIL unmapped: got %b/%h want 1/0", readValid, dataOut);
    end
    bus_read(BASE + 32'h100);
    tests++;
    if (readValid !== 1'b0 || dataOut !== 32'h0) begin
      fails++; $display("FAIL outside: got %b/%h want 0/0", readValid, dataOut);
    end
    bus_read(BASE | 32'h6);
    tests++;
    if (readValid !== 1'b1 || dataOut !== {16'h0, m_out}) begin
      fails++;
      $display("FAIL lowbits: got %b/%h want 1/%h", readValid, dataOut, m_out);
    end
  endtask

  task automatic test_random();
    logic [1:0] op;
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      tests++;
      if (leds !== m_out) begin
        fails++; $display("FAIL rnd_leds c%0d: got %h want %h", c, leds, m_out);
      end
      tests++;
      if (irq !== m_irq) begin
        fails++; $display("FAIL rnd_irq c%0d: got %b want %b", c, irq, m_irq);
      end
      tests++;
      if (readValid !== m_rv || dataOut !== m_dout) begin
        fails++;
        $display("FAIL rnd_read c%0d: got %b/%h want %b/%h",
                 c, readValid, dataOut, m_rv, m_dout);
      end
      for (int b = 0; b < 16; b++)
        if ($urandom_range(0, 11) == 0) sw[b] = ~sw[b];
      op = 2'($urandom);
      if ($urandom_range(0, 7) == 0) address = BASE + 32'h100;
      else address = BASE | 32'($urandom_range(0, 8) * 4)
                          | 32'($urandom_range(0, 3));
      readEnable = op[0];
      wbs = op[1] ? 4'($urandom) : 4'h0;
      dataIn = $urandom;
    end
    @(negedge clk);
    readEnable = 1'b0;
    wbs = 4'h0;
    sw = 16'h0;
    idle(15);
  endtask

  task automatic test_reset_mid();
    bus_write(8'h04, 32'hFFFF, 4'hF);
    sw[5] = 1'b1;
    idle(3);
    address = BASE | 32'h4;
    readEnable = 1'b1;
    #2 rst = 1'b0;
    #1;
    tests++;
    if (leds !== 16'h0 || irq !== 1'b0 || readValid !== 1'b0 || dataOut !== 32'h0) begin
      fails++;
      $display("FAIL rst_mid: got %h/%b/%b/%h want 0/0/0/0",
               leds, irq, readValid, dataOut);
    end
    @(negedge clk);
    readEnable = 1'b0;
    sw = 16'h0;
    idle(1);
    rst = 1'b1;
    idle(3);
    tests++;
    if (readValid !== 1'b0 || leds !== 16'h0) begin
      fails++; $display("FAIL rst_release: got %b/%h want 0/0", readValid, leds);
    end
    bus_read(BASE);
    tests++;
    if (dataOut !== 32'h0) begin
      fails++; $display("FAIL rst_deb_discard: got %h want 0", dataOut);
    end
  endtask

  initial begin
    test_reset();
    test_rw();
    test_debounce();
    sw = 16'h0;
    idle(12);
    test_glitch();
    test_falling();
    test_w1c_race();
    test_unmapped();
    test_random();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: run did not finish");
    $fatal(1);
  end

endmodule
